// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: writes the in-window, decimated camera pixel stream into the
// frame-buffer BRAM write port through a 2-stage pipeline (S1 = accepted pixel,
// S2 = write-port register) and pulses frame_done_out once a full window is written.
// Optional feature macro: FRAME_BUFFER_WRITER_DOUBLE_BUFFER_EN (adds buf_sel_out and
// prefixes wr_addr_out with it; ADDR_W then carries one extra bit).
module frame_buffer_writer #(
  parameter int unsigned WIDTH      = 240,
  parameter int unsigned HEIGHT     = 320,
  parameter int unsigned DECIM_LOG2 = 0,
  parameter int unsigned ADDR_W     = 17
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              capture_en_in,
  input  logic              frame_start_in,
  input  logic              pixel_valid_in,
  output logic              pixel_ready_out,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic [15:0]       pixel_in,
  output logic              wr_en_out,
  input  logic              wr_ready_in,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [15:0]       wr_data_out,
  output logic              frame_done_out,
  output logic              busy_out
`ifdef FRAME_BUFFER_WRITER_DOUBLE_BUFFER_EN
  ,
  output logic              buf_sel_out
`endif
);

`ifdef FRAME_BUFFER_WRITER_DOUBLE_BUFFER_EN
  localparam int unsigned LinW = ADDR_W - 1;
`else
  localparam int unsigned LinW = ADDR_W;
`endif
  localparam int unsigned WinW  = WIDTH >> DECIM_LOG2;
  localparam logic [10:0] HMask = 11'((32'd1 << DECIM_LOG2) - 32'd1);
  localparam logic [9:0]  VMask = 10'((32'd1 << DECIM_LOG2) - 32'd1);

  typedef enum logic [1:0] {StIdle, StWaitFrame, StCapture, StDrain} state_e;

  state_e            state_q;
  logic              s1_valid_q;
  logic              s1_keep_q;
  logic [LinW-1:0]   s1_addr_q;
  logic [15:0]       s1_data_q;

  logic              s2_free;
  logic              s1_adv;
  logic              accept;
  logic              keep;
  logic              last_pix;
  logic [LinW-1:0]   lin_addr;

  // Handshake, keep flag and linear address for the pixel on the input bus
  always_comb begin
    s2_free         = !wr_en_out || wr_ready_in;
    s1_adv          = s1_valid_q && s2_free;
    pixel_ready_out = (state_q != StDrain) && (!s1_valid_q || s2_free);
    accept          = pixel_valid_in && pixel_ready_out;
    keep            = (state_q == StCapture) &&
                      (32'(hcount_in) < WIDTH) && (32'(vcount_in) < HEIGHT) &&
                      ((hcount_in & HMask) == 11'd0) && ((vcount_in & VMask) == 10'd0);
    // Address derives from the counts, so dropped source pixels never shift it
    lin_addr        = LinW'(((32'(vcount_in) >> DECIM_LOG2) * WinW) +
                            (32'(hcount_in) >> DECIM_LOG2));
    last_pix        = (hcount_in == 11'(WIDTH - 1)) && (vcount_in == 10'(HEIGHT - 1));
  end

  // S1: holds the accepted pixel until S2 can take it (dropped pixels just retire)
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid_q <= 1'b0;
      s1_keep_q  <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_keep_q  <= keep;
      s1_addr_q  <= lin_addr;
      s1_data_q  <= pixel_in;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  // S2: write-port register; address/data hold while the port stalls
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_en_out   <= 1'b0;
      wr_addr_out <= '0;
      wr_data_out <= '0;
    end else if (s2_free) begin
      wr_en_out <= s1_valid_q && s1_keep_q;
      if (s1_valid_q && s1_keep_q) begin
`ifdef FRAME_BUFFER_WRITER_DOUBLE_BUFFER_EN
        wr_addr_out <= {buf_sel_out, s1_addr_q};
`else
        wr_addr_out <= s1_addr_q;
`endif
        wr_data_out <= s1_data_q;
      end
    end
  end

  // Frame-level control with registered busy/done (and buffer select) outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q        <= StIdle;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
`ifdef FRAME_BUFFER_WRITER_DOUBLE_BUFFER_EN
      buf_sel_out    <= 1'b0;
`endif
    end else begin
      frame_done_out <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (capture_en_in) state_q <= StWaitFrame;
        end
        StWaitFrame: begin
          if (frame_start_in) begin
            if (capture_en_in) begin
              state_q  <= StCapture;
              busy_out <= 1'b1;
            end else begin
              state_q  <= StIdle;
            end
          end
        end
        StCapture: begin
          // A frame_start here is an aborted frame: keep capturing, no done pulse
          if (accept && last_pix) state_q <= StDrain;
        end
        StDrain: begin
          if (!s1_valid_q && !wr_en_out) begin
            frame_done_out <= 1'b1;
            busy_out       <= 1'b0;
            state_q        <= capture_en_in ? StWaitFrame : StIdle;
`ifdef FRAME_BUFFER_WRITER_DOUBLE_BUFFER_EN
            buf_sel_out    <= ~buf_sel_out;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer: two instances (no decimation 6x4 window,
// decimate-by-2 8x6 window) fed from a 10x7 raster source.
module tb_frame_buffer_writer;

  localparam int SrcW = 10;
  localparam int SrcH = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cap0, cap1, fs0, fs1, v0, v1, rdy0, rdy1;
  logic [10:0] hc;
  logic [9:0]  vc;
  logic [15:0] pix;
  logic        wr_ready;
  logic        wen0, wen1, done0, done1, busy0, busy1;
  logic [7:0]  wa0, wa1;
  logic [15:0] wd0, wd1;

  always #5 clk = ~clk;

  frame_buffer_writer #(.WIDTH(6), .HEIGHT(4), .DECIM_LOG2(0), .ADDR_W(8)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .capture_en_in(cap0), .frame_start_in(fs0),
    .pixel_valid_in(v0), .pixel_ready_out(rdy0), .hcount_in(hc), .vcount_in(vc),
    .pixel_in(pix), .wr_en_out(wen0), .wr_ready_in(wr_ready), .wr_addr_out(wa0),
    .wr_data_out(wd0), .frame_done_out(done0), .busy_out(busy0)
  );

  frame_buffer_writer #(.WIDTH(8), .HEIGHT(6), .DECIM_LOG2(1), .ADDR_W(8)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .capture_en_in(cap1), .frame_start_in(fs1),
    .pixel_valid_in(v1), .pixel_ready_out(rdy1), .hcount_in(hc), .vcount_in(vc),
    .pixel_in(pix), .wr_en_out(wen1), .wr_ready_in(wr_ready), .wr_addr_out(wa1),
    .wr_data_out(wd1), .frame_done_out(done1), .busy_out(busy1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int bp_mode  = 0;
  int exp_idx0 = 0, exp_idx1 = 0, nwr0 = 0, nwr1 = 0, ndone0 = 0, ndone1 = 0;
  int acc_cyc0 = 0, first_wr0 = 0, stall_run0 = 0;
  logic        stall0 = 1'b0, pv0 = 1'b0;
  logic [7:0]  pa0;
  logic [15:0] pd0;
  logic [15:0] mem1 [0:15];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] pix_of(input int h, input int v);
    return {v[7:0], h[7:0]};
  endfunction

  always @(posedge clk) cyc++;

  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode == 0) wr_ready = 1'b1;
      else if (bp_mode == 1) wr_ready = 1'($urandom_range(0, 1));
      else wr_ready = 1'b0;
    end
  end

  always @(negedge rst_n) begin
    stall0     = 1'b0;
    stall_run0 = 0;
  end

  // Write monitors: in-order addresses, data from the source pixel, stall stability
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall0) begin
        check("wr0_hold_en", 32'(wen0), 32'd1);
        check("wr0_hold_addr", 32'(wa0), 32'(pa0));
        check("wr0_hold_data", 32'(wd0), 32'(pd0));
      end
      if (wen0 && !wr_ready) stall_run0++;
      else stall_run0 = 0;
      if (stall_run0 >= 2 && pv0) check("rdy0_drop", 32'(rdy0), 32'd0);
      if (wen0 && wr_ready) begin
        if (exp_idx0 == 0) first_wr0 = cyc;
        check("wr0_addr", 32'(wa0), 32'(exp_idx0));
        check("wr0_data", 32'(wd0), 32'(pix_of(exp_idx0 % 6, exp_idx0 / 6)));
        exp_idx0++;
        nwr0++;
      end
      stall0 = wen0 && !wr_ready;
      pa0    = wa0;
      pd0    = wd0;
      pv0    = v0;
      if (done0) ndone0++;
      if (wen1 && wr_ready) begin
        check("wr1_addr", 32'(wa1), 32'(exp_idx1));
        check("wr1_data", 32'(wd1), 32'(pix_of((exp_idx1 % 4) * 2, (exp_idx1 / 4) * 2)));
        mem1[wa1[3:0]] = wd1;
        exp_idx1++;
        nwr1++;
      end
      if (done1) ndone1++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle gap, frame_start pulse, then a raster of `rows` source lines
  task automatic send_frame(input int which, input int rows, input int drop_row,
                            input logic exp_busy);
    int t;
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (3) tick();
    if (which == 0) begin exp_idx0 = 0; fs0 = 1'b1; end
    else begin exp_idx1 = 0; fs1 = 1'b1; end
    tick();
    fs0 = 1'b0;
    fs1 = 1'b0;
    @(negedge clk);
    check("busy_at_start", 32'(which == 0 ? busy0 : busy1), 32'(exp_busy));
    tick();
    for (int v = 0; v < rows; v++) begin
      for (int h = 0; h < SrcW; h++) begin
        if (which == 0 && v == drop_row && h == 0) cap0 = 1'b0;
        hc  = 11'(h);
        vc  = 10'(v);
        pix = pix_of(h, v);
        if (which == 0) v0 = 1'b1;
        else v1 = 1'b1;
        t = 0;
        forever begin
          @(negedge clk);
          if ((which == 0) ? rdy0 : rdy1) break;
          t++;
          if (t > 200) begin
            $display("FAIL accept_timeout: got no ready expected ready within 200 cycles");
            $fatal(1);
          end
        end
        if (which == 0 && h == 0 && v == 0) acc_cyc0 = cyc;
        tick();
      end
    end
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  int base;

  initial begin
    rst_n = 1'b0;
    cap0 = 1'b0; cap1 = 1'b0; fs0 = 1'b0; fs1 = 1'b0; v0 = 1'b0; v1 = 1'b0;
    hc = '0; vc = '0; pix = '0;
    #2;
    check("rst_wen", 32'(wen0), 32'd0);
    check("rst_addr", 32'(wa0), 32'd0);
    check("rst_data", 32'(wd0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_ready", 32'(rdy0), 32'd1);
    tick();
    rst_n = 1'b1;

    // Full frame, no backpressure
    cap0 = 1'b1;
    tick();
    send_frame(0, SrcH, -1, 1'b1);
    repeat (6) tick();
    check("f1_writes", 32'(nwr0), 32'd24);
    check("f1_done", 32'(ndone0), 32'd1);
    check("f1_latency", 32'(first_wr0 - acc_cyc0), 32'd2);
    check("f1_busy_after", 32'(busy0), 32'd0);

    // Random backpressure
    base = nwr0;
    bp_mode = 1;
    send_frame(0, SrcH, -1, 1'b1);
    bp_mode = 0;
    repeat (10) tick();
    check("bp_writes", 32'(nwr0 - base), 32'd24);
    check("bp_done", 32'(ndone0), 32'd2);

    // Aborted frame after two lines, then a full one
    base = nwr0;
    send_frame(0, 2, -1, 1'b1);
    repeat (5) tick();
    check("abort_writes", 32'(nwr0 - base), 32'd12);
    check("abort_no_done", 32'(ndone0), 32'd2);
    check("abort_busy", 32'(busy0), 32'd1);
    base = nwr0;
    send_frame(0, SrcH, -1, 1'b1);
    repeat (6) tick();
    check("after_abort_writes", 32'(nwr0 - base), 32'd24);
    check("after_abort_done", 32'(ndone0), 32'd3);

    // capture_en drops mid-frame: frame completes, next frame ignored
    base = nwr0;
    send_frame(0, SrcH, 1, 1'b1);
    repeat (6) tick();
    check("capoff_writes", 32'(nwr0 - base), 32'd24);
    check("capoff_done", 32'(ndone0), 32'd4);
    check("capoff_busy", 32'(busy0), 32'd0);
    base = nwr0;
    send_frame(0, SrcH, -1, 1'b0);
    repeat (6) tick();
    check("idle_writes", 32'(nwr0 - base), 32'd0);
    check("idle_done", 32'(ndone0), 32'd4);
    check("idle_busy", 32'(busy0), 32'd0);

    // Decimate by 2
    cap1 = 1'b1;
    tick();
    send_frame(1, SrcH, -1, 1'b1);
    repeat (6) tick();
    check("d1_writes", 32'(nwr1), 32'd12);
    check("d1_done", 32'(ndone1), 32'd1);
    check("d1_pix_6_4", 32'(mem1[11]), 32'(pix_of(6, 4)));
    check("d1_pix_2_2", 32'(mem1[5]), 32'(pix_of(2, 2)));

    // Asynchronous reset while a write is stalled
    cap0 = 1'b1;
    tick();
    fs0 = 1'b1;
    tick();
    fs0 = 1'b0;
    bp_mode = 2;
    tick();
    hc = 11'd1; vc = 10'd0; pix = pix_of(1, 0); v0 = 1'b1;
    tick();
    v0 = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("pre_rst_wen", 32'(wen0), 32'd1);
    check("pre_rst_addr", 32'(wa0), 32'd1);
    check("pre_rst_data", 32'(wd0), 32'(pix_of(1, 0)));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wen", 32'(wen0), 32'd0);
    check("arst_addr", 32'(wa0), 32'd0);
    check("arst_data", 32'(wd0), 32'd0);
    check("arst_busy", 32'(busy0), 32'd0);
    check("arst_ready", 32'(rdy0), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bp_mode = 0;
    cap0 = 1'b0;
    tick();
    @(negedge clk);
    check("post_rst_ready", 32'(rdy0), 32'd1);
    check("post_rst_busy", 32'(busy0), 32'd0);
    check("post_rst_wen", 32'(wen0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
